// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, instruction queue, redirect flush.
// Optional FETCH_BYPASS_EN: a response reaches ID in its arrival cycle when the queue is empty.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall_ID,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid_ID,
  output logic [31:0]     instr_ID,
  output logic [XLEN-1:0] pc_ID,
  output logic [XLEN-1:0] pc_plus4_ID,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int AW = $clog2(QDEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight, drop, count;
  logic [XLEN-1:0] last_pc;

  logic [31:0]     iq_instr [QDEPTH];
  logic [XLEN-1:0] iq_pc    [QDEPTH];
  logic [AW-1:0]   iq_head, iq_tail;

  // PCs of issued requests, matched to responses in issue order (stale ones included).
  logic [XLEN-1:0] pq_pc [QDEPTH];
  logic [AW-1:0]   pq_head, pq_tail;

  logic            accept, rsp_live, bypass, push, pop;
  logic [CW:0]     occupancy;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign dbg_state      = state;

  // Handshakes: a request transfers when imem_req_valid && imem_req_ready; the address
  // stays stable until then. ID consumes instr_ID/pc_ID when valid_ID && !stall_ID.
  assign accept    = imem_req_valid && imem_req_ready;
  assign occupancy = (CW+1)'(inflight) + (CW+1)'(count);
  assign rsp_live  = imem_rsp_valid && !redirect && (drop == '0);
`ifdef FETCH_BYPASS_EN
  assign bypass    = rsp_live && (count == '0);
`else
  assign bypass    = 1'b0;
`endif
  assign pop       = (count != '0) && !stall_ID;
  assign push      = rsp_live && !(bypass && !stall_ID);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        BOOT:    state_nxt = RUN;
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    imem_req_valid = !rst && (state == RUN) && !redirect && (occupancy < (CW+1)'(QDEPTH));
    imem_req_addr  = fetch_pc;
    valid_ID       = (count != '0) || bypass;
    instr_ID       = NOP;
    pc_ID          = last_pc;
    if (count != '0) begin
      instr_ID = iq_instr[iq_head];
      pc_ID    = iq_pc[iq_head];
    end else if (bypass) begin
      instr_ID = imem_rsp_data[31:0];
      pc_ID    = pq_pc[pq_head];
    end
    pc_plus4_ID = pc_ID + XLEN'(4);
  end

  // Control and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      iq_head  <= '0;
      iq_tail  <= '0;
      pq_head  <= '0;
      pq_tail  <= '0;
      last_pc  <= RESET_PC;
    end else begin
      if (valid_ID)       last_pc <= pc_ID;
      if (accept)         pq_tail <= pq_tail + AW'(1);
      if (imem_rsp_valid) pq_head <= pq_head + AW'(1);
      inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Everything still outstanding belongs to the abandoned path.
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop     <= inflight - CW'(imem_rsp_valid);
        count    <= '0;
        iq_head  <= '0;
        iq_tail  <= '0;
      end else begin
        if (accept)                          fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && drop != '0)    drop     <= drop - CW'(1);
        if (push)                            iq_tail  <= iq_tail + AW'(1);
        if (pop)                             iq_head  <= iq_head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; pointers and counters qualify them.
  always_ff @(posedge clk) begin
    if (accept) pq_pc[pq_tail] <= fetch_pc;
    if (push && !rst) begin
      iq_instr[iq_tail] <= imem_rsp_data[31:0];
      iq_pc[iq_tail]    <= pq_pc[pq_head];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-level model.
// Compile with +define+FETCH_BYPASS_EN to check the same-cycle bypass variant.
module tb_fetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic        stall_ID, redirect, valid_ID;
  logic [31:0] instr_ID, pc_ID, pc_plus4_ID;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_ID(stall_ID), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_ID(valid_ID), .instr_ID(instr_ID), .pc_ID(pc_ID), .pc_plus4_ID(pc_plus4_ID),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus knobs applied on each step
  logic        rst_v = 1'b1, ready_v = 1'b0, stall_v = 1'b0, redir_v = 1'b0;
  logic [31:0] redir_pc_v = '0;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;

  // Memory model: accepted requests waiting to be answered in order
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];

  // Reference model: in-flight fetches (stale after a redirect) and buffered {pc, word}
  typedef struct { logic [31:0] pc; bit stale; } fly_t;
  fly_t        fly_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc = RESET_PC, m_last_pc = RESET_PC;
  int          m_mode = 0;  // 0 boot, 1 run, 2 flush
  bit          model_ok = 0;

  // Logs of what the DUT actually did, for the directed literal checks
  logic [31:0] acc_log[$], con_pc[$], con_instr[$], con_p4[$];
  int          rsp20_cyc = -1, show20_cyc = -1;
  logic [31:0] show20_instr = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h20) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  function automatic logic [31:0] qget(ref logic [31:0] q[$], input int i);
    if (i < 0 || i >= q.size()) return 32'hxxxx_xxxx;
    return q[i];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, then advance the model.
  task automatic step();
    bit          rsp_now, byp, e_valid, e_req, do_pop;
    logic [31:0] e_instr, e_pc;
    fly_t        f;
    @(negedge clk);
    rst            = rst_v;
    imem_req_ready = ready_v;
    stall_ID       = stall_v;
    redirect       = redir_v;
    redirect_pc    = redir_pc_v;
    rsp_now = !rst_v && mem_q.size() > 0 && mem_q[0].due <= cyc &&
              ($urandom_range(0, 99) < rsp_pct);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
    #1;

    e_req = !rst_v && m_mode == 1 && !redir_v && (fly_q.size() + exp_q.size() < QDEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rsp_now && !redir_v && exp_q.size() == 0 && fly_q.size() > 0 && !fly_q[0].stale;
`endif
    e_valid = exp_q.size() > 0 || byp;
    e_instr = exp_q.size() > 0 ? exp_q[0][31:0]  : (byp ? mem_word(fly_q[0].pc) : NOP);
    e_pc    = exp_q.size() > 0 ? exp_q[0][63:32] : (byp ? fly_q[0].pc : m_last_pc);

    if (model_ok) begin
      chk("req_valid",   {31'd0, imem_req_valid}, {31'd0, e_req});
      chk("req_addr",    imem_req_addr, m_fetch_pc);
      chk("valid_ID",    {31'd0, valid_ID}, {31'd0, e_valid});
      chk("instr_ID",    instr_ID, e_instr);
      chk("pc_ID",       pc_ID, e_pc);
      chk("pc_plus4_ID", pc_plus4_ID, e_pc + 32'd4);
    end

    if (rsp_now && mem_q[0].addr == 32'h20 && rsp20_cyc < 0) rsp20_cyc = cyc;
    if (valid_ID && pc_ID == 32'h20 && show20_cyc < 0) begin
      show20_cyc   = cyc;
      show20_instr = instr_ID;
    end
    if (!rst_v && valid_ID && !stall_v && !redir_v) begin
      con_pc.push_back(pc_ID);
      con_instr.push_back(instr_ID);
      con_p4.push_back(pc_plus4_ID);
    end

    // Memory side follows what the DUT really issued
    if (rst_v) begin
      mem_q.delete();
    end else begin
      if (rsp_now) void'(mem_q.pop_front());
      if (imem_req_valid && ready_v) begin
        mem_q.push_back('{imem_req_addr, cyc + $urandom_range(lat_min, lat_max)});
        acc_log.push_back(imem_req_addr);
      end
    end

    // Model update
    if (rst_v) begin
      m_fetch_pc = RESET_PC;
      m_last_pc  = RESET_PC;
      m_mode     = 0;
      fly_q.delete();
      exp_q.delete();
      model_ok   = 1;
    end else begin
      if (e_valid) m_last_pc = e_pc;
      do_pop = exp_q.size() > 0 && !stall_v;
      if (do_pop) void'(exp_q.pop_front());
      if (rsp_now && fly_q.size() > 0) begin
        f = fly_q.pop_front();
        if (!redir_v && !f.stale && !(byp && !stall_v)) exp_q.push_back({f.pc, mem_word(f.pc)});
      end
      if (e_req && ready_v) begin
        fly_q.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redir_v) begin
        exp_q.delete();
        foreach (fly_q[i]) fly_q[i].stale = 1'b1;
        m_fetch_pc = {redir_pc_v[31:2], 2'b00};
        m_mode     = 2;
      end else begin
        m_mode = 1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1; redir_v = 1'b0;
    step(); step();
    rst_v = 1'b0;
  endtask

  initial begin
    int n_acc, n_con, bad, k;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall_ID = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset values while rst is held
    ready_v = 1'b1; stall_v = 1'b0; lat_min = 1; lat_max = 1; rsp_pct = 100;
    do_reset();
    chk("rst_valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("rst_instr_ID", instr_ID, NOP);
    chk("rst_pc_ID", pc_ID, RESET_PC);
    chk("rst_pc_plus4", pc_plus4_ID, RESET_PC + 32'd4);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Streaming with 1-cycle latency, no stall
    acc_log.delete(); con_pc.delete(); con_instr.delete(); con_p4.delete();
    repeat (12) step();
    chk("seq_addr0", qget(acc_log, 0), 32'h0);
    chk("seq_addr1", qget(acc_log, 1), 32'h4);
    chk("seq_addr2", qget(acc_log, 2), 32'h8);
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", qget(con_pc, i), 32'(4 * i));
      chk("seq_instr", qget(con_instr, i), mem_word(32'(4 * i)));
      chk("seq_pc_plus4", qget(con_p4, i), 32'(4 * i + 4));
    end

    // Stall 5 cycles: queue fills, requests stop, nothing lost on release
    stall_v = 1'b1;
    repeat (5) step();
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_valid_ID", {31'd0, valid_ID}, 32'd1);
    stall_v = 1'b0;
    repeat (10) step();
    bad = 0;
    for (int i = 1; i < con_pc.size(); i++) if (con_pc[i] != con_pc[i-1] + 32'd4) bad++;
    chk("stall_no_loss_dup", 32'(bad), 32'd0);

    // Request held while ready is low
    do_reset();
    acc_log.delete();
    for (k = 0; k < 20 && acc_log.size() < 2; k++) step();
    if (acc_log.size() < 2) chk("timeout_hold", 32'(acc_log.size()), 32'd2);
    ready_v = 1'b0;
    repeat (3) begin
      step();
      chk("hold_addr", imem_req_addr, 32'h8);
    end
    ready_v = 1'b1;
    for (k = 0; k < 20 && acc_log.size() < 3; k++) step();
    chk("hold_next_addr", qget(acc_log, 2), 32'h8);

    // Redirect to 0x103 with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    for (k = 0; k < 20 && fly_q.size() < 2; k++) step();
    if (fly_q.size() < 2) chk("timeout_redirect", 32'(fly_q.size()), 32'd2);
    n_acc = acc_log.size(); n_con = con_pc.size();
    redir_v = 1'b1; redir_pc_v = 32'h103;
    step();
    redir_v = 1'b0;
    repeat (15) step();
    chk("redir_addr", qget(acc_log, n_acc), 32'h100);
    chk("redir_first_pc", qget(con_pc, n_con), 32'h100);
    chk("redir_first_instr", qget(con_instr, n_con), mem_word(32'h100));

    // Reset with one request in flight
    do_reset();
    for (k = 0; k < 20 && fly_q.size() < 1; k++) step();
    rst_v = 1'b1; step(); rst_v = 1'b0;
    step();
    chk("midrst_valid_ID", {31'd0, valid_ID}, 32'd0);
    chk("midrst_instr_ID", instr_ID, NOP);
    n_acc = acc_log.size();
    for (k = 0; k < 20 && acc_log.size() == n_acc; k++) step();
    chk("midrst_restart", qget(acc_log, n_acc), RESET_PC);

    // Response at PC 0x20 arriving with an empty queue
    lat_min = 1; lat_max = 1;
    do_reset();
    ready_v = 1'b0;
    repeat (3) step();
    redir_v = 1'b1; redir_pc_v = 32'h20; step(); redir_v = 1'b0;
    ready_v = 1'b1; rsp20_cyc = -1; show20_cyc = -1;
    repeat (8) step();
    chk("byp_instr", show20_instr, 32'h00A0_0093);
`ifdef FETCH_BYPASS_EN
    chk("byp_latency", 32'(show20_cyc - rsp20_cyc), 32'd0);
`else
    chk("byp_latency", 32'(show20_cyc - rsp20_cyc), 32'd1);
`endif

    // Wrap of the PC space
    n_con = con_pc.size();
    redir_v = 1'b1; redir_pc_v = 32'hFFFF_FFFE; step(); redir_v = 1'b0;
    repeat (12) step();
    chk("wrap_pc", qget(con_pc, n_con), 32'hFFFF_FFFC);
    chk("wrap_plus4", qget(con_p4, n_con), 32'h0);
    chk("wrap_next_pc", qget(con_pc, n_con + 1), 32'h0);

    // Random traffic
    for (int phase = 0; phase < 3; phase++) begin
      lat_min = 1; lat_max = 1 + 2 * phase; rsp_pct = 60 + 15 * phase;
      repeat (1200) begin
        rst_v      = ($urandom_range(0, 299) == 0);
        ready_v    = ($urandom_range(0, 99) < 70);
        stall_v    = ($urandom_range(0, 99) < 30);
        redir_v    = ($urandom_range(0, 99) < 4);
        redir_pc_v = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
